// File: rtl/prio_encoder_hs.sv
// Registered N:log2(N) priority encoder with a valid/ready output handshake.
// Resolves either by fixed priority (highest index) or round-robin from a rotating pointer.
module prio_encoder_hs #(
    parameter int N = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [N-1:0]               req,
    input  logic                       mode,
    input  logic                       out_ready,
    output logic                       out_valid,
    output logic [$clog2(N)-1:0]       out_idx,
    output logic [N-1:0]               out_onehot,
    output logic                       multi,
    output logic [$clog2(N+1)-1:0]     req_cnt
);

    localparam int IDX_W = $clog2(N);
    localparam int CNT_W = $clog2(N + 1);

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic               out_valid_q, out_valid_d;
    logic [IDX_W-1:0]   out_idx_q, out_idx_d;
    logic [N-1:0]       out_onehot_q, out_onehot_d;
    logic               multi_q, multi_d;
    logic [CNT_W-1:0]   req_cnt_q, req_cnt_d;

    logic               accept;
    logic               load;
    logic [IDX_W-1:0]   ptr_next;
    logic [IDX_W-1:0]   ptr_eff;
    logic [IDX_W-1:0]   fix_idx;
    logic [IDX_W-1:0]   rr_idx;
    logic               rr_found;
    logic [IDX_W-1:0]   win_idx;
    logic [CNT_W-1:0]   pop;
    int                 rr_pos;

    assign accept   = (state_q == HOLD) && out_ready;
    assign load     = (req != '0) && ((state_q == IDLE) || accept);
    // Explicit compare keeps the wrap right when N is not a power of two.
    assign ptr_next = (out_idx_q == IDX_W'(N - 1)) ? '0 : out_idx_q + 1'b1;
    assign ptr_eff  = accept ? ptr_next : ptr_q;

    always_comb begin
        fix_idx = '0;
        pop     = '0;
        for (int i = 0; i < N; i++) begin
            if (req[i]) begin
                fix_idx = IDX_W'(i);
            end
            pop = pop + CNT_W'(req[i]);
        end
    end

    // Round-robin: first set bit at or above ptr_eff, wrapping past N-1 to 0.
    always_comb begin
        rr_found = 1'b0;
        rr_idx   = '0;
        rr_pos   = 0;
        for (int k = 0; k < N; k++) begin
            rr_pos = int'(ptr_eff) + k;
            if (rr_pos >= N) begin
                rr_pos = rr_pos - N;
            end
            if (!rr_found && req[rr_pos]) begin
                rr_found = 1'b1;
                rr_idx   = IDX_W'(rr_pos);
            end
        end
    end

    assign win_idx = mode ? rr_idx : fix_idx;

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_eff;
        out_valid_d  = out_valid_q;
        out_idx_d    = out_idx_q;
        out_onehot_d = out_onehot_q;
        multi_d      = multi_q;
        req_cnt_d    = req_cnt_q;
        if (load) begin
            state_d      = HOLD;
            out_valid_d  = 1'b1;
            out_idx_d    = win_idx;
            out_onehot_d = {{(N-1){1'b0}}, 1'b1} << win_idx;
            multi_d      = (pop > CNT_W'(1));
            req_cnt_d    = pop;
        end else if (accept) begin
            state_d     = IDLE;
            out_valid_d = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            ptr_q        <= '0;
            out_valid_q  <= 1'b0;
            out_idx_q    <= '0;
            out_onehot_q <= '0;
            multi_q      <= 1'b0;
            req_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            out_valid_q  <= out_valid_d;
            out_idx_q    <= out_idx_d;
            out_onehot_q <= out_onehot_d;
            multi_q      <= multi_d;
            req_cnt_q    <= req_cnt_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_idx    = out_idx_q;
    assign out_onehot = out_onehot_q;
    assign multi      = multi_q;
    assign req_cnt    = req_cnt_q;

endmodule

// File: tb/tb_prio_encoder_hs.sv
// Directed bench for prio_encoder_hs: an N=8 and an N=5 instance share clock, reset, mode and ready.
module tb_prio_encoder_hs;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       mode = 1'b0;
    logic       out_ready = 1'b0;
    logic [7:0] req8 = '0;
    logic [4:0] req5 = '0;

    logic       v8, m8;
    logic [2:0] idx8;
    logic [7:0] oh8;
    logic [3:0] cnt8;
    logic       v5, m5;
    logic [2:0] idx5;
    logic [4:0] oh5;
    logic [2:0] cnt5;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    prio_encoder_hs #(.N(8)) u8 (
        .clk(clk), .rst_n(rst_n), .req(req8), .mode(mode), .out_ready(out_ready),
        .out_valid(v8), .out_idx(idx8), .out_onehot(oh8), .multi(m8), .req_cnt(cnt8)
    );

    prio_encoder_hs #(.N(5)) u5 (
        .clk(clk), .rst_n(rst_n), .req(req5), .mode(mode), .out_ready(out_ready),
        .out_valid(v5), .out_idx(idx5), .out_onehot(oh5), .multi(m5), .req_cnt(cnt5)
    );

    // Packed view {valid, idx, onehot, multi, cnt} of the N=8 outputs.
    wire [16:0] obs8 = {v8, idx8, oh8, m8, cnt8};
    wire [13:0] obs5 = {v5, idx5, oh5, m5, cnt5};

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #3;
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if (obs8 !== 17'd0 || obs5 !== 14'd0) begin
            errors++;
            $display("FAIL reset_outputs: got8=%h got5=%h want 0", obs8, obs5);
        end
        rst_n = 1'b1;
        step();
        checks++;
        if (v8 !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: out_valid=%b want 0", v8);
        end
    endtask

    task automatic test_fixed_single();
        logic [16:0] exp;
        mode = 1'b0;
        out_ready = 1'b1;
        for (int j = 0; j < 8; j++) begin
            req8 = 8'd1 << j;
            step();
            exp = {1'b1, 3'(j), 8'd1 << j, 1'b0, 4'd1};
            checks++;
            if (obs8 !== exp) begin
                errors++;
                $display("FAIL fixed_single[%0d]: got=%h want=%h", j, obs8, exp);
            end
        end
        req8 = '0;
        step();
        checks++;
        if (v8 !== 1'b0) begin
            errors++;
            $display("FAIL fixed_single_idle: out_valid=%b want 0", v8);
        end
    endtask

    task automatic test_hold_freeze();
        logic [16:0] exp;
        exp = {1'b1, 3'd7, 8'h80, 1'b1, 4'd4};
        mode = 1'b0;
        out_ready = 1'b0;
        req8 = 8'b1010_0101;
        step();
        checks++;
        if (obs8 !== exp) begin
            errors++;
            $display("FAIL hold_load: got=%h want=%h", obs8, exp);
        end
        req8 = 8'h0F;
        mode = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            checks++;
            if (obs8 !== exp) begin
                errors++;
                $display("FAIL hold_frozen[%0d]: got=%h want=%h", c, obs8, exp);
            end
        end
        req8 = '0;
        mode = 1'b0;
        out_ready = 1'b1;
        step();
        checks++;
        if (obs8 !== {1'b0, exp[15:0]}) begin
            errors++;
            $display("FAIL hold_release: got=%h want=%h", obs8, {1'b0, exp[15:0]});
        end
    endtask

    task automatic test_rr_all();
        int seq [10] = '{0, 1, 2, 3, 4, 5, 6, 7, 0, 1};
        do_reset();
        mode = 1'b1;
        out_ready = 1'b1;
        req8 = 8'hFF;
        for (int c = 0; c < 10; c++) begin
            step();
            checks++;
            if (v8 !== 1'b1 || idx8 !== 3'(seq[c]) || oh8 !== (8'd1 << seq[c]) || cnt8 !== 4'd8) begin
                errors++;
                $display("FAIL rr_all[%0d]: valid=%b idx=%0d oh=%h cnt=%0d want idx=%0d", c, v8, idx8, oh8, cnt8, seq[c]);
            end
        end
        req8 = '0;
        step();
    endtask

    task automatic test_rr_wrap();
        int exp_idx;
        mode = 1'b1;
        out_ready = 1'b1;
        req8 = 8'b0000_0011;
        for (int c = 0; c < 4; c++) begin
            step();
            exp_idx = c % 2;
            checks++;
            if (v8 !== 1'b1 || idx8 !== 3'(exp_idx) || m8 !== 1'b1 || cnt8 !== 4'd2) begin
                errors++;
                $display("FAIL rr_wrap[%0d]: valid=%b idx=%0d multi=%b cnt=%0d want idx=%0d", c, v8, idx8, m8, cnt8, exp_idx);
            end
        end
        req8 = '0;
        step();
    endtask

    task automatic test_async_reset();
        mode = 1'b0;
        out_ready = 1'b1;
        req8 = 8'h10;
        step();
        req8 = 8'h20;
        step();
        out_ready = 1'b0;
        step();
        checks++;
        if (v8 !== 1'b1 || idx8 !== 3'd5) begin
            errors++;
            $display("FAIL areset_setup: valid=%b idx=%0d want 1/5", v8, idx8);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (obs8 !== 17'd0) begin
            errors++;
            $display("FAIL areset_immediate: got=%h want 0", obs8);
        end
        rst_n = 1'b1;
        mode = 1'b1;
        out_ready = 1'b1;
        req8 = 8'h81;
        step();
        checks++;
        if (v8 !== 1'b1 || idx8 !== 3'd0 || oh8 !== 8'h01) begin
            errors++;
            $display("FAIL areset_ptr: valid=%b idx=%0d oh=%h want 1/0/01", v8, idx8, oh8);
        end
        req8 = '0;
        step();
    endtask

    task automatic test_n5_wrap();
        logic [13:0] exp;
        mode = 1'b1;
        out_ready = 1'b1;
        req5 = 5'b10001;
        for (int c = 0; c < 4; c++) begin
            step();
            exp = (c % 2 == 0) ? {1'b1, 3'd0, 5'b00001, 1'b1, 3'd2}
                               : {1'b1, 3'd4, 5'b10000, 1'b1, 3'd2};
            checks++;
            if (obs5 !== exp) begin
                errors++;
                $display("FAIL n5_wrap[%0d]: got=%h want=%h", c, obs5, exp);
            end
        end
        req5 = '0;
        for (int c = 0; c < 2; c++) begin
            step();
            checks++;
            if (v5 !== 1'b0) begin
                errors++;
                $display("FAIL n5_idle[%0d]: out_valid=%b want 0", c, v5);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_fixed_single();
        test_hold_freeze();
        test_rr_all();
        test_rr_wrap();
        test_async_reset();
        test_n5_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
